// File: rtl/bits_pkg.sv
// Shared constants and digit types for the binary-clock display path.
package bits_pkg;

  localparam int NUM_COLS = 4;
  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX  = 9;

  typedef logic [DIGIT_W-1:0]          digit_t;
  typedef logic [NUM_COLS*DIGIT_W-1:0] digits_t;

  // Extract digit k from a packed digit word.
  function automatic digit_t get_digit(input digits_t word, input int idx);
    return word[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Column scan timebase: slot counter within a column, column index, and
// decode of the frame boundary and first-slot-of-frame conditions.
module scan_timer #(
  parameter int SCAN_DIV = 32,
  parameter int NUM_COLS = 4
) (
  input  logic                          hwclk,
  input  logic                          rst,
  output logic [$clog2(SCAN_DIV)-1:0]   slot_cnt,
  output logic [$clog2(NUM_COLS)-1:0]   col_idx,
  output logic                          frame_boundary,
  output logic                          frame_first
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int COL_W  = $clog2(NUM_COLS);

  logic slot_wrap;

  assign slot_wrap      = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign frame_boundary = slot_wrap && (col_idx == COL_W'(NUM_COLS - 1));
  assign frame_first    = (slot_cnt == '0) && (col_idx == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      slot_cnt <= '0;
      col_idx  <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      col_idx  <= frame_boundary ? '0 : col_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_matrix_scan.sv
// Column-multiplexed 4x4 LED driver for BCD digits: double-buffered frames,
// per-slot blanking, global PWM brightness and a sticky bad-digit flag.
module bcd_matrix_scan
  import bits_pkg::*;
#(
  parameter int SCAN_DIV = 32,
  parameter int PWM_BITS = 4,
  parameter int BLANK    = 2
) (
  input  logic                hwclk,
  input  logic                rst,
  input  digits_t             digits,
  input  logic                digits_valid,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [NUM_COLS-1:0] col_n,
  output logic [DIGIT_W-1:0]  row,
  output logic                frame_start,
  output logic                digit_err
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int COL_W  = $clog2(NUM_COLS);

  logic [SLOT_W-1:0]   slot_cnt;
  logic [COL_W-1:0]    col_idx;
  logic                frame_boundary;
  logic                frame_first;

  digits_t             shadow_buf;
  digits_t             active_buf;
  digit_t              cur_digit;
  logic                digit_bad;
  logic [PWM_BITS-1:0] pwm_phase;
  logic                lit;
  logic [NUM_COLS-1:0] col_onehot;

  scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .NUM_COLS (NUM_COLS)
  ) u_scan_timer (
    .hwclk          (hwclk),
    .rst            (rst),
    .slot_cnt       (slot_cnt),
    .col_idx        (col_idx),
    .frame_boundary (frame_boundary),
    .frame_first    (frame_first)
  );

  // SCAN_DIV is a multiple of the PWM period, so slot mod period is just the low bits.
  assign pwm_phase = slot_cnt[PWM_BITS-1:0];
  assign lit       = (slot_cnt >= SLOT_W'(BLANK)) && (pwm_phase < brightness);
  assign cur_digit = get_digit(active_buf, int'(col_idx));
  assign digit_bad = (cur_digit > digit_t'(BCD_MAX));

  // NOTE: every variable driven here gets a default first, so no path leaves
  // a bit unassigned and no latch is inferred.
  always_comb begin
    col_onehot          = '0;
    col_onehot[col_idx] = 1'b1;
  end

  // NOTE: the digit buffers are reset explicitly; they are a few flops,
  // not a RAM, and a defined blank frame after reset is wanted.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      shadow_buf  <= '0;
      active_buf  <= '0;
      col_n       <= '1;
      row         <= '0;
      frame_start <= 1'b0;
      digit_err   <= 1'b0;
    end else begin
      // A boundary strobe also lands in the shadow so the value persists.
      if (digits_valid) shadow_buf <= digits;
      if (frame_boundary) active_buf <= digits_valid ? digits : shadow_buf;

      col_n       <= lit ? ~col_onehot : '1;
      row         <= (lit && !digit_bad) ? cur_digit : '0;
      frame_start <= frame_first;
      if (lit && digit_bad) digit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_matrix_scan.sv
// Scoreboard bench: a frame-position reference model predicts every output
// cycle; a negedge monitor compares the DUT against the queued predictions.
module tb_bcd_matrix_scan;
  import bits_pkg::*;

  localparam int SCAN_DIV = 32;
  localparam int PWM_BITS = 4;
  localparam int BLANK    = 2;
  localparam int FRAME    = NUM_COLS * SCAN_DIV;

  logic          hwclk = 1'b0;
  logic          rst = 1'b1;
  logic          digits_valid = 1'b0;
  digits_t       digits = '0;
  logic [3:0]    brightness = '0;
  logic [3:0]    col_n;
  logic [3:0]    row;
  logic          frame_start;
  logic          digit_err;

  always #5 hwclk = ~hwclk;

  bcd_matrix_scan #(
    .SCAN_DIV (SCAN_DIV),
    .PWM_BITS (PWM_BITS),
    .BLANK    (BLANK)
  ) dut (
    .hwclk        (hwclk),
    .rst          (rst),
    .digits       (digits),
    .digits_valid (digits_valid),
    .brightness   (brightness),
    .col_n        (col_n),
    .row          (row),
    .frame_start  (frame_start),
    .digit_err    (digit_err)
  );

  typedef struct packed {
    logic [3:0] col_n;
    logic [3:0] row;
    logic       fs;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   m_n;          // clock edges since reset = position within the scan
  int   m_shadow;
  int   m_active;
  bit   m_err;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: position p in the frame gives slot and column directly.
  always @(posedge hwclk) begin : ref_model
    exp_t e;
    int   p, slot, col, d;
    bit   lit;
    if (rst) begin
      m_n = 0; m_shadow = 0; m_active = 0; m_err = 1'b0;
      e = '{col_n: 4'hF, row: 4'h0, fs: 1'b0, err: 1'b0};
    end else begin
      p    = m_n % FRAME;
      slot = p % SCAN_DIV;
      col  = p / SCAN_DIV;
      d    = (m_active >> (4 * col)) & 15;
      lit  = (slot >= BLANK) && ((slot % (1 << PWM_BITS)) < int'(brightness));
      if (lit && d > 9) m_err = 1'b1;
      e.col_n = lit ? 4'(~(1 << col)) : 4'hF;
      e.row   = (lit && d <= 9) ? 4'(d) : 4'h0;
      e.fs    = (p == 0);
      e.err   = m_err;
      if (p == FRAME - 1) m_active = digits_valid ? int'(digits) : m_shadow;
      if (digits_valid) m_shadow = int'(digits);
      m_n++;
    end
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge hwclk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("col_n",       col_n,               e.col_n);
      check("row",         row,                 e.row);
      check("frame_start", {3'b000, frame_start}, {3'b000, e.fs});
      check("digit_err",   {3'b000, digit_err},   {3'b000, e.err});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic strobe(input digits_t v);
    digits       = v;
    digits_valid = 1'b1;
    @(negedge hwclk);
    digits_valid = 1'b0;
  endtask

  // Advance to the negedge preceding the edge that samples frame position pos.
  task automatic wait_pos(input int pos);
    int guard = 0;
    while ((m_n % FRAME) != pos && guard < 2 * FRAME) begin
      @(negedge hwclk);
      guard++;
    end
    vectors++;
    if (guard >= 2 * FRAME) begin
      miscompares++;
      $display("FAIL wait_pos timeout: got position %0d, expected %0d", m_n % FRAME, pos);
    end
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;

    // Full brightness with 9,3,0,7
    brightness = 4'd15;
    strobe(16'h9307);
    tick(2 * FRAME + 10);

    // Brightness 0 then 1 for one whole frame each
    wait_pos(0);
    brightness = 4'd0;
    tick(FRAME);
    brightness = 4'd1;
    tick(FRAME);
    brightness = 4'd15;

    // Mid-frame strobe must not tear the current frame
    wait_pos(48);
    strobe(16'h1111);
    tick(2 * FRAME);

    // Boundary strobe followed immediately by a second strobe
    strobe(16'h4242);
    tick(FRAME + 5);
    wait_pos(FRAME - 1);
    strobe(16'h2468);
    strobe(16'h5555);
    tick(2 * FRAME);

    // Invalid digit in column 2, then reset mid-slot with a coincident strobe
    strobe(16'h0C00);
    tick(2 * FRAME);
    wait_pos(70);
    rst          = 1'b1;
    digits       = 16'h7777;
    digits_valid = 1'b1;
    tick(1);
    digits_valid = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(FRAME + 10);

    // Randomised traffic: brightness changes, strobes, occasional resets
    repeat (3000) begin
      @(negedge hwclk);
      if ($urandom_range(15) == 0) brightness = 4'($urandom);
      digits       = digits_t'($urandom);
      digits_valid = ($urandom_range(39) == 0);
      rst          = ($urandom_range(699) == 0);
    end
    digits_valid = 1'b0;
    rst          = 1'b0;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
